// File: rtl/fifo_pkg.sv
// Shared parameters and read-side state encoding for the async FIFO and its consumers.
package fifo_pkg;

    localparam int DEF_DW   = 3;
    localparam int DEF_PACK = 4;

    typedef enum logic {
        S_FILL,
        S_FLUSH
    } rd_state_t;

endpackage

// File: rtl/pack_buf.sv
// Slot-indexed packing buffer: the Nth word of a beat lands in slot N and cnt tracks
// how many slots hold data. Slot 0 drives the least significant bits of data.
module pack_buf
    import fifo_pkg::*;
#(
    parameter int DW   = DEF_DW,
    parameter int PACK = DEF_PACK,
    parameter int CW   = $clog2(PACK + 1)
) (
    input  logic               rclk,
    input  logic               rrst_n,
    input  logic               wr_en,
    input  logic [DW-1:0]      wr_data,
    input  logic               clr,
    output logic [CW-1:0]      cnt,
    output logic [DW*PACK-1:0] data
);

    logic [DW-1:0] slot [PACK];

    // Clearing zeroes every slot so a partial beat carries zeros above its last word;
    // a word arriving in the clearing cycle opens the next beat in slot 0.
    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt <= '0;
            for (int i = 0; i < PACK; i++) slot[i] <= '0;
        end else if (clr) begin
            cnt <= wr_en ? CW'(1) : '0;
            for (int i = 0; i < PACK; i++) slot[i] <= (i == 0 && wr_en) ? wr_data : '0;
        end else if (wr_en && cnt != CW'(PACK)) begin
            cnt <= cnt + CW'(1);
            for (int i = 0; i < PACK; i++) begin
                if (cnt == CW'(i)) slot[i] <= wr_data;
            end
        end
    end

    for (genvar g = 0; g < PACK; g++) begin : g_out
        assign data[g*DW +: DW] = slot[g];
    end

endmodule

// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: drains words in the rclk domain, packs PACK of them per
// valid/ready beat, and pushes out a partial beat on a flush request.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int  DW   = DEF_DW,
    parameter int  PACK = DEF_PACK,
    localparam int CW   = $clog2(PACK + 1)
) (
    input  logic               rclk,
    input  logic               rrst_n,
    input  logic               empty,
    input  logic [DW-1:0]      rdata,
    output logic               ren,
    input  logic               flush,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [DW*PACK-1:0] m_data,
    output logic [CW-1:0]      m_count,
    output logic               busy
);

    localparam logic [CW:0] PACK_LIM = (CW + 1)'(PACK);

    rd_state_t          state, state_next;
    logic               inflight;
    logic               flush_pend;
    logic               flush_done;
    logic               load_req;
    logic               load;
    logic               out_free;
    logic [CW-1:0]      cnt;
    logic [DW*PACK-1:0] buf_data;
    logic [CW:0]        pending;

    pack_buf #(
        .DW   (DW),
        .PACK (PACK),
        .CW   (CW)
    ) u_buf (
        .rclk    (rclk),
        .rrst_n  (rrst_n),
        .wr_en   (inflight),
        .wr_data (rdata),
        .clr     (load),
        .cnt     (cnt),
        .data    (buf_data)
    );

    // Counting the outstanding read keeps the buffer from being over-requested,
    // and ren stays low during reset even if the FIFO still reports data.
    assign pending  = {1'b0, cnt} + {{CW{1'b0}}, inflight};
    assign ren      = rrst_n && !empty && (state == S_FILL) && !flush_pend && (pending < PACK_LIM);
    assign out_free = !m_valid || m_ready;
    assign load     = load_req && out_free;
    assign busy     = flush_pend || (cnt != '0) || inflight;

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state      <= S_FILL;
            inflight   <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= ren;
            if (flush)           flush_pend <= 1'b1;
            else if (flush_done) flush_pend <= 1'b0;
        end
    end

    // A flush waits for the outstanding read to land so the partial beat is complete.
    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        flush_done = 1'b0;
        case (state)
            S_FILL: begin
                load_req = (cnt == CW'(PACK));
                if (flush_pend && !inflight) state_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (cnt == '0) begin
                    state_next = S_FILL;
                    flush_done = 1'b1;
                end else begin
                    load_req = 1'b1;
                    if (out_free) begin
                        state_next = S_FILL;
                        flush_done = 1'b1;
                    end
                end
            end
            default: state_next = S_FILL;
        endcase
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            m_valid <= 1'b0;
            m_data  <= '0;
            m_count <= '0;
        end else if (load) begin
            m_valid <= 1'b1;
            m_data  <= buf_data;
            m_count <= cnt;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

endmodule
